// File: rtl/edge_win_out_framer_if.sv
// Pixel-stream bundle between the window/edge-filter pipeline and the
// output framer. The master drives the shift strobe and filter result; the
// slave (the framer) returns the framed stream and flow-control flags.
interface edge_win_out_framer_if #(
   parameter int DATA_W = 24
);
   logic              shift_en;
   logic              sof_in;
   logic [DATA_W-1:0] edge_in;
   logic [DATA_W-1:0] pix_out;
   logic              out_valid;
   logic [9:0]        out_x;
   logic [8:0]        out_y;
   logic              out_border;
   logic              out_eol;
   logic              out_eof;
   logic              flush_req;
   logic              frame_err;

   modport master (
      output shift_en, sof_in, edge_in,
      input  pix_out, out_valid, out_x, out_y, out_border,
             out_eol, out_eof, flush_req, frame_err
   );

   modport slave (
      input  shift_en, sof_in, edge_in,
      output pix_out, out_valid, out_x, out_y, out_border,
             out_eol, out_eof, flush_req, frame_err
   );
endinterface

// File: rtl/edge_win_out_framer.sv
// Output framer for the 3x3 line-buffer window pipeline. Absorbs the
// one-line-plus-one-pixel priming latency, tags each filtered pixel with its
// output coordinates and line/frame markers, substitutes a constant on the
// frame border, and requests flush shifts to drain the last row.
module edge_win_out_framer #(
   parameter int                 H_ACTIVE   = 640,
   parameter int                 V_ACTIVE   = 480,
   parameter int                 DATA_W     = 24,
   parameter logic [DATA_W-1:0]  BORDER_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   edge_win_out_framer_if.slave  fr
);

   // Window centre for input n appears P shifts later.
   localparam int          P       = H_ACTIVE + 1;
   localparam int          TOTAL   = H_ACTIVE * V_ACTIVE;
   localparam logic [18:0] TOTAL_C = 19'(TOTAL);
   localparam logic [10:0] P_C     = 11'(P);
   localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
   localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [18:0]         in_cnt_q, in_cnt_d;
   logic [10:0]         prime_cnt_q, prime_cnt_d;
   logic [9:0]          ox_q, ox_d;
   logic [8:0]          oy_q, oy_d;

   logic [DATA_W-1:0]   pix_q, pix_d;
   logic                valid_q, valid_d;
   logic [9:0]          x_q, x_d;
   logic [8:0]          y_q, y_d;
   logic                border_q, border_d;
   logic                eol_q, eol_d;
   logic                eof_q, eof_d;
   logic                flush_q, flush_d;
   logic                ferr_q, ferr_d;

   logic                restart;
   logic                emit;
   logic                at_eol;
   logic                at_eof;
   logic                on_border;
   logic [18:0]         in_cnt_inc;

   assign restart    = fr.shift_en & fr.sof_in;
   assign emit       = fr.shift_en & ~fr.sof_in & ((state_q == RUN) | (state_q == DRAIN));
   assign at_eol     = (ox_q == X_LAST);
   assign at_eof     = at_eol & (oy_q == Y_LAST);
   assign on_border  = (ox_q == 10'd0) | at_eol | (oy_q == 9'd0) | (oy_q == Y_LAST);
   // Input count saturates at one full frame; later shifts are flush dummies.
   assign in_cnt_inc = (in_cnt_q == TOTAL_C) ? in_cnt_q : in_cnt_q + 19'd1;

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         prime_cnt_q <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         pix_q       <= '0;
         valid_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         border_q    <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         flush_q     <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         prime_cnt_q <= prime_cnt_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         pix_q       <= pix_d;
         valid_q     <= valid_d;
         x_q         <= x_d;
         y_q         <= y_d;
         border_q    <= border_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         flush_q     <= flush_d;
         ferr_q      <= ferr_d;
      end
   end

   // Next state and counters; nothing moves without a shift.
   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      prime_cnt_d = prime_cnt_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      if (restart) begin
         // A sof always (re)starts a frame, abandoning any frame in flight.
         state_d     = FILL;
         in_cnt_d    = 19'd1;
         prime_cnt_d = 11'd1;
         ox_d        = '0;
         oy_d        = '0;
      end else if (fr.shift_en) begin
         case (state_q)
            FILL: begin
               in_cnt_d    = in_cnt_inc;
               prime_cnt_d = prime_cnt_q + 11'd1;
               if (prime_cnt_q + 11'd1 == P_C) begin
                  ox_d    = '0;
                  oy_d    = '0;
                  state_d = (in_cnt_inc == TOTAL_C) ? DRAIN : RUN;
               end
            end
            RUN, DRAIN: begin
               in_cnt_d = in_cnt_inc;
               if (at_eol) begin
                  ox_d = '0;
                  oy_d = oy_q + 9'd1;
               end else begin
                  ox_d = ox_q + 10'd1;
               end
               if (at_eof) begin
                  state_d     = IDLE;
                  in_cnt_d    = '0;
                  prime_cnt_d = '0;
                  ox_d        = '0;
                  oy_d        = '0;
               end else if ((state_q == RUN) && (in_cnt_inc == TOTAL_C)) begin
                  state_d = DRAIN;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs; markers only accompany a valid pixel.
   always_comb begin
      valid_d  = emit;
      pix_d    = pix_q;
      x_d      = x_q;
      y_d      = y_q;
      if (emit) begin
         pix_d = on_border ? BORDER_VAL : fr.edge_in;
         x_d   = ox_q;
         y_d   = oy_q;
      end
      border_d = emit & on_border;
      eol_d    = emit & at_eol;
      eof_d    = emit & at_eof;
      flush_d  = (state_d == DRAIN);
      ferr_d   = restart & (state_q != IDLE);
   end

   assign fr.pix_out    = pix_q;
   assign fr.out_valid  = valid_q;
   assign fr.out_x      = x_q;
   assign fr.out_y      = y_q;
   assign fr.out_border = border_q;
   assign fr.out_eol    = eol_q;
   assign fr.out_eof    = eof_q;
   assign fr.flush_req  = flush_q;
   assign fr.frame_err  = ferr_q;

endmodule

// File: tb/tb_edge_win_out_framer.sv
// Directed bench for the output framer on an 8x4 frame (P = 9).
module tb_edge_win_out_framer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n = 1000;          // shift index within the current frame
   int   outs, eols, eofs, ferrs;
   logic flush_exp = 1'b0;

   always #5 clk = ~clk;

   edge_win_out_framer_if #(.DATA_W(24)) sif ();

   edge_win_out_framer #(
      .H_ACTIVE   (8),
      .V_ACTIVE   (4),
      .DATA_W     (24),
      .BORDER_VAL (24'h000000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fr    (sif.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic drive(input logic en, input logic sof, input logic [23:0] d);
      @(negedge clk);
      sif.shift_en = en;
      sif.sof_in   = sof;
      sif.edge_in  = d;
      @(posedge clk);
      #1;
      if (sif.out_valid === 1'b1) outs++;
      if (sif.out_eol === 1'b1) eols++;
      if (sif.out_eof === 1'b1) eofs++;
      if (sif.frame_err === 1'b1) ferrs++;
      $display("shift=%0b sof=%0b n=%0d valid=%0b x=%0d y=%0d pix=%h brd=%0b eol=%0b eof=%0b flush=%0b ferr=%0b",
               en, sof, n, sif.out_valid, sif.out_x, sif.out_y, sif.pix_out,
               sif.out_border, sif.out_eol, sif.out_eof, sif.flush_req, sif.frame_err);
   endtask

   // One frame shift, optionally preceded by idle gap cycles, fully checked.
   task automatic fshift(input logic sof, input int gaps);
      int idx, ex, ey;
      logic eb;
      for (int g = 0; g < gaps; g++) begin
         drive(1'b0, 1'b0, 24'hABCDEF);
         chk("gap_valid", 32'(sif.out_valid), 32'd0);
         chk("gap_flush", 32'(sif.flush_req), 32'(flush_exp));
      end
      if (sof) n = 1; else n++;
      drive(1'b1, sof, 24'h123456);
      if (n >= 10 && n <= 41) begin
         idx = n - 10;
         ex  = idx % 8;
         ey  = idx / 8;
         eb  = (ex == 0) || (ex == 7) || (ey == 0) || (ey == 3);
         chk("valid",  32'(sif.out_valid), 32'd1);
         chk("x",      32'(sif.out_x), 32'(ex));
         chk("y",      32'(sif.out_y), 32'(ey));
         chk("border", 32'(sif.out_border), 32'(eb));
         chk("pix",    32'(sif.pix_out), eb ? 32'h0 : 32'h123456);
         chk("eol",    32'(sif.out_eol), 32'(ex == 7));
         chk("eof",    32'(sif.out_eof), 32'(ex == 7 && ey == 3));
      end else begin
         chk("no_valid", 32'(sif.out_valid), 32'd0);
      end
      flush_exp = (n >= 32 && n <= 40);
      chk("flush", 32'(sif.flush_req), 32'(flush_exp));
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_pix"},    32'(sif.pix_out), 32'd0);
      chk({pfx, "_valid"},  32'(sif.out_valid), 32'd0);
      chk({pfx, "_x"},      32'(sif.out_x), 32'd0);
      chk({pfx, "_y"},      32'(sif.out_y), 32'd0);
      chk({pfx, "_border"}, 32'(sif.out_border), 32'd0);
      chk({pfx, "_eol"},    32'(sif.out_eol), 32'd0);
      chk({pfx, "_eof"},    32'(sif.out_eof), 32'd0);
      chk({pfx, "_flush"},  32'(sif.flush_req), 32'd0);
      chk({pfx, "_ferr"},   32'(sif.frame_err), 32'd0);
   endtask

   initial begin
      sif.shift_en = 1'b0;
      sif.sof_in   = 1'b0;
      sif.edge_in  = '0;

      // Reset state.
      reset = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 24'h0);
      chk_all_zero("rst");
      reset = 1'b0;

      // Shifts without sof are ignored while idle.
      fshift(1'b0, 0);
      fshift(1'b0, 0);

      // Frame A: continuous shifts, priming latency, full frame, flush timing.
      outs = 0; eols = 0; eofs = 0; ferrs = 0;
      fshift(1'b1, 0);
      for (int i = 0; i < 40; i++) fshift(1'b0, 0);
      chk("a_outs", 32'(outs), 32'd32);
      chk("a_eols", 32'(eols), 32'd4);
      chk("a_eofs", 32'(eofs), 32'd1);
      chk("a_ferr", 32'(ferrs), 32'd0);
      fshift(1'b0, 0);
      fshift(1'b0, 0);

      // Frame B: random gaps must not disturb coordinates or counts.
      outs = 0; eols = 0; eofs = 0; ferrs = 0;
      fshift(1'b1, 0);
      for (int i = 0; i < 40; i++) fshift(1'b0, int'($urandom_range(0, 2)));
      chk("b_outs", 32'(outs), 32'd32);
      chk("b_eols", 32'(eols), 32'd4);
      chk("b_eofs", 32'(eofs), 32'd1);
      chk("b_ferr", 32'(ferrs), 32'd0);

      // Reset in the middle of RUN (after an output has been produced).
      fshift(1'b1, 0);
      for (int i = 0; i < 14; i++) fshift(1'b0, 0);
      @(negedge clk);
      reset        = 1'b1;
      sif.shift_en = 1'b1;
      sif.sof_in   = 1'b0;
      @(posedge clk);
      #1;
      chk_all_zero("midrst");
      reset     = 1'b0;
      n         = 1000;
      flush_exp = 1'b0;
      fshift(1'b0, 0);
      fshift(1'b0, 0);

      // Early sof at output (3,2): shift 29 of a frame.
      outs = 0; eols = 0; eofs = 0; ferrs = 0;
      fshift(1'b1, 0);
      chk("idle_sof_no_err", 32'(sif.frame_err), 32'd0);
      for (int i = 0; i < 27; i++) fshift(1'b0, 0);
      chk("pre_abort_outs", 32'(outs), 32'd19);
      fshift(1'b1, 0);
      chk("abort_ferr", 32'(sif.frame_err), 32'd1);
      fshift(1'b0, 0);
      chk("ferr_clear", 32'(sif.frame_err), 32'd0);
      for (int i = 0; i < 39; i++) fshift(1'b0, 0);
      chk("e_ferrs", 32'(ferrs), 32'd1);
      chk("e_eofs", 32'(eofs), 32'd1);
      chk("e_outs", 32'(outs), 32'd51);
      fshift(1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/edge_win_out_framer.md
# edge_win_out_framer

Output-side framer for the 3x3 line-buffer window pipeline. It sits after the edge filter and consumes the same per-pixel `shift_en` strobe that advances the row RAMs and shift registers. It absorbs the one-line-plus-one-pixel window latency and emits the filtered stream with the correct output coordinates, end-of-line and end-of-frame markers, and border substitution where the 3x3 window is incomplete. It also requests the flush shifts needed to drain the last row out of the line buffers.

## Interface
- `H_ACTIVE`, 640, active pixels per line (row RAM depth)
- `V_ACTIVE`, 480, active lines per frame
- `DATA_W`, 24, pixel width (RGB888)
- `BORDER_VAL`, 24'h000000, pixel substituted on frame border

Ports:
- `clk`  in  1  pixel clock; single clock domain
- `reset`  in  1  synchronous, active-high
- `shift_en`  in  1  one pulse per pixel shift through the window pipeline
- `sof_in`  in  1  first pixel of a frame; sampled only while `shift_en`=1
- `edge_in`  in  DATA_W  filter result for the current window centre
- `pix_out`  out  DATA_W  framed output pixel
- `out_valid`  out  1  `pix_out` and coordinates valid this cycle
- `out_x`  out  10  output column, 0..H_ACTIVE-1
- `out_y`  out  9  output row, 0..V_ACTIVE-1
- `out_border`  out  1  current output pixel lies on the frame border
- `out_eol`  out  1  last pixel of a line (with `out_valid`)
- `out_eof`  out  1  last pixel of the frame (with `out_valid`)
- `flush_req`  out  1  upstream must keep pulsing `shift_en` with dummy pixels
- `frame_err`  out  1  one-cycle pulse: a new frame started before the previous one drained

## Operation
- Prime constant: P = H_ACTIVE+1 = 641. The window centre for input index n appears at shift n+P.
- Counters:
  - `in_cnt`: 19-bit count of accepted input pixels
  - `prime_cnt`: 11-bit
  - `ox` / `oy`: output position
- FSM states are IDLE, FILL, RUN, DRAIN. Reset state is IDLE.
- IDLE:
  - Ignores `shift_en` unless `sof_in`=1.
  - On `shift_en`&`sof_in`: in_cnt=1, prime_cnt=1, go to FILL.
- FILL:
  - Each `shift_en` increments in_cnt and prime_cnt. No output.
  - When prime_cnt reaches P on a shift, go to RUN with ox=0, oy=0. The first output is produced on the next shift.
- RUN:
  - Each `shift_en` produces one output at (ox,oy), then advances ox.
  - ox wraps at H_ACTIVE-1 to 0, and oy increments on the wrap.
  - in_cnt saturates at H_ACTIVE*V_ACTIVE. When it reaches that value, go to DRAIN.
- DRAIN:
  - `flush_req`=1. Output continues on each `shift_en`.
  - The output at (H_ACTIVE-1, V_ACTIVE-1) asserts `out_eof`. After it, return to IDLE and deassert `flush_req`.
- Border rule: `out_border` = (ox==0) | (ox==H_ACTIVE-1) | (oy==0) | (oy==V_ACTIVE-1).
- Pixel select: `pix_out` = `out_border` ? BORDER_VAL : `edge_in`.
- `out_eol` = (ox==H_ACTIVE-1). `out_eof` = `out_eol` & (oy==V_ACTIVE-1).
- `sof_in`&`shift_en` in FILL, RUN or DRAIN:
  - Pulse `frame_err`, abandon the old frame and clear all counters.
  - Restart as if accepted from IDLE: in_cnt=1, prime_cnt=1, state FILL.
  - No output is emitted for that shift.
- `shift_en`=0: all state holds and `out_valid`=0.
- Reset mid-frame: return to IDLE at the next edge. Pending output is discarded.

## Timing
- All outputs are registered. `out_valid` and its data appear one cycle after the qualifying `shift_en`.
- `edge_in` is sampled in the same cycle as `shift_en`.
- End-to-end: first `out_valid` is one cycle after the (P+1)th shift of the frame (sof shift counted as shift 1).
- Reset values: `pix_out`=0, `out_valid`=0, `out_x`=0, `out_y`=0, `out_border`=0, `out_eol`=0, `out_eof`=0, `flush_req`=0, `frame_err`=0.
- `flush_req` rises one cycle after the shift that makes in_cnt = H_ACTIVE*V_ACTIVE. It falls one cycle after the `out_eof` shift.
- Outputs per frame: exactly H_ACTIVE*V_ACTIVE. Required upstream shifts: H_ACTIVE*V_ACTIVE + P.
- Back-to-back shift_en every cycle sustains one output per cycle. There are no bubbles after FILL.

## Test plan
- Reset check (H_ACTIVE=8, V_ACTIVE=4): assert `reset` mid-RUN. Next cycle all outputs are 0 and state is IDLE. `shift_en` without `sof_in` produces no output.
- Priming latency (H_ACTIVE=8, V_ACTIVE=4, P=9):
  - Continuous `shift_en` with sof on shift 1.
  - First `out_valid` is one cycle after shift 10, with x=0, y=0, `out_border`=1, `pix_out`=0.
- Full frame (H_ACTIVE=8, V_ACTIVE=4), `edge_in`=24'h123456:
  - Exactly 32 valid outputs.
  - Interior pixels (x 1..6, y 1..2) carry 24'h123456; all others carry 0.
  - `out_eol` appears 4 times; `out_eof` once, at (7,3).
- Flush (H_ACTIVE=8, V_ACTIVE=4):
  - `flush_req` rises one cycle after shift 32 and falls one cycle after shift 41.
  - Random `shift_en` gaps do not change coordinates or count.
- Early sof: assert `sof_in`&`shift_en` at output (3,2). `frame_err` pulses once, the next output is (0,0) after 9 more shifts, and no `out_eof` is emitted for the aborted frame.
- Default params: one full frame of 640x480 yields 307200 outputs and 640+641-... border count 2236. The run needs 307841 total shifts.
